// File: rtl/regfile_flags.sv
// Register file (R0 hardwired to zero) with two combinational read ports and one write
// port, plus the C/Z status flag register that feeds the ALU carry-in and branch logic.
module regfile_flags #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wd,
    input  logic              flag_we,
    input  logic [2:0]        aluop,
    input  logic              c_in,
    input  logic              z_in,
    output logic              c_flag,
    output logic              z_flag
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              carry_op;

    // Logical ops (100/101/110) leave carry untouched; add/sub and ror update it.
    assign carry_op = (aluop[2] == 1'b0) || (aluop == 3'b111);

    // No write-to-read bypass: a read in the write cycle sees the old contents.
    assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa_addr != '0)) begin
            regs[wa_addr] <= wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_flag <= 1'b0;
            z_flag <= 1'b0;
        end else if (flag_we) begin
            z_flag <= z_in;
            if (carry_op) begin
                c_flag <= c_in;
            end
        end
    end

endmodule
